// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-byte write priority, optional write-to-read
// bypass, a per-register busy scoreboard and a post-reset zeroing sweep.
module regfile_mp_sb #(
    parameter int NR_RD  = 4,
    parameter int NR_WR  = 2,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NR_RD*AW-1:0]      raddr,
    output logic [NR_RD*DW-1:0]      rdata,
    output logic [NR_RD-1:0]         rbusy,
    input  logic [NR_WR*(DW/8)-1:0]  we,
    input  logic [NR_WR*AW-1:0]      waddr,
    input  logic [NR_WR*DW-1:0]      wdata,
    input  logic [NR_WR-1:0]         iss_valid,
    input  logic [NR_WR*AW-1:0]      iss_addr,
    output logic                     init_done
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q;
    logic [AW-1:0]    cnt_q;
    logic             init_done_q;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DW-1:0]    rf_q [DEPTH];

    assign init_done = init_done_q;

    // Scoreboard next state: clears first, then issue sets so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NR_WR; j++) begin
            if (we[j*NB +: NB] != {NB{1'b0}}) begin
                busy_d[waddr[j*AW +: AW]] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
        end
        for (int j = 0; j < NR_WR; j++) begin
            if (iss_valid[j] && (iss_addr[j*AW +: AW] != {AW{1'b0}})) begin
                busy_d[iss_addr[j*AW +: AW]] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // Combinational read path with optional same-cycle forwarding.
    always_comb begin : rd_path
        logic [AW-1:0] ra;
        logic [DW-1:0] d;
        logic          bz;
        ra    = {AW{1'b0}};
        d     = {DW{1'b0}};
        bz    = 1'b0;
        rdata = {(NR_RD*DW){1'b0}};
        rbusy = {NR_RD{1'b0}};
        for (int i = 0; i < NR_RD; i++) begin
            ra = raddr[i*AW +: AW];
            d  = rf_q[ra];
            bz = busy_q[ra];
            if (BYPASS != 0) begin
                // Ascending port order lets the youngest port overwrite each byte.
                for (int j = 0; j < NR_WR; j++) begin
                    for (int b = 0; b < NB; b++) begin
                        if ((waddr[j*AW +: AW] == ra) && we[j*NB + b]) begin
                            d[b*8 +: 8] = wdata[j*DW + b*8 +: 8];
                        end else begin
                            d[b*8 +: 8] = d[b*8 +: 8];
                        end
                    end
                    if ((waddr[j*AW +: AW] == ra) && (we[j*NB +: NB] != {NB{1'b0}})) begin
                        bz = 1'b0;
                    end else begin
                        bz = bz;
                    end
                end
            end else begin
                d = d;
            end
            if ((state_q == RUN) && (ra != {AW{1'b0}})) begin
                rdata[i*DW +: DW] = d;
                rbusy[i]          = bz;
            end else begin
                rdata[i*DW +: DW] = {DW{1'b0}};
                rbusy[i]          = 1'b0;
            end
        end
    end

    // Control FSM, zeroing sweep, storage writes and scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= {AW{1'b0}};
            init_done_q <= 1'b0;
            busy_q      <= {DEPTH{1'b0}};
        end else begin
            case (state_q)
                INIT: begin
                    rf_q[cnt_q] <= {DW{1'b0}};
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    busy_q <= busy_d;
                    // Later NBAs win, so higher-index ports take priority per byte.
                    for (int j = 0; j < NR_WR; j++) begin
                        for (int b = 0; b < NB; b++) begin
                            if (we[j*NB + b] && (waddr[j*AW +: AW] != {AW{1'b0}})) begin
                                rf_q[waddr[j*AW +: AW]][b*8 +: 8] <= wdata[j*DW + b*8 +: 8];
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= INIT;
                    cnt_q       <= {AW{1'b0}};
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypass and non-bypass instances share stimulus and
// are checked against a behavioural model, directed vectors and sweep sequences.
module tb_regfile_mp_sb;

    logic          clk;
    logic          reset;
    logic [19:0]   raddr;
    logic [7:0]    we;
    logic [9:0]    waddr;
    logic [63:0]   wdata;
    logic [1:0]    iss_valid;
    logic [9:0]    iss_addr;
    logic [127:0]  rdata_b, rdata_n;
    logic [3:0]    rbusy_b, rbusy_n;
    logic          init_b, init_n;

    int n_checks = 0;
    int n_err    = 0;

    regfile_mp_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .init_done(init_b));

    regfile_mp_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_addr(iss_addr), .init_done(init_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the architectural state.
    logic [31:0] m_rf [32];
    logic        m_busy [32];
    logic        m_run = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_read(input logic byp, input int i, output logic [31:0] d, output logic bz);
        logic [4:0] a;
        a  = raddr[i*5 +: 5];
        d  = 32'h0;
        bz = 1'b0;
        if (m_run && a != 5'd0) begin
            d  = m_rf[a];
            bz = m_busy[a];
            if (byp) begin
                for (int j = 0; j < 2; j++) begin
                    if (waddr[j*5 +: 5] == a) begin
                        for (int b = 0; b < 4; b++)
                            if (we[j*4 + b]) d[b*8 +: 8] = wdata[j*32 + b*8 +: 8];
                        if (we[j*4 +: 4] != 4'h0) bz = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_run = 1'b0;
            m_cnt = 0;
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else if (!m_run) begin
            m_rf[m_cnt] = 32'h0;
            if (m_cnt == 31) m_run = 1'b1;
            else m_cnt++;
        end else begin
            for (int j = 0; j < 2; j++)
                for (int b = 0; b < 4; b++)
                    if (we[j*4 + b] && waddr[j*5 +: 5] != 5'd0)
                        m_rf[waddr[j*5 +: 5]][b*8 +: 8] = wdata[j*32 + b*8 +: 8];
            for (int j = 0; j < 2; j++)
                if (we[j*4 +: 4] != 4'h0) m_busy[waddr[j*5 +: 5]] = 1'b0;
            for (int j = 0; j < 2; j++)
                if (iss_valid[j] && iss_addr[j*5 +: 5] != 5'd0) m_busy[iss_addr[j*5 +: 5]] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [31:0] d;
        logic        bz;
        for (int i = 0; i < 4; i++) begin
            model_read(1'b1, i, d, bz);
            chk($sformatf("byp rdata%0d", i), rdata_b[i*32 +: 32], d);
            chk($sformatf("byp rbusy%0d", i), {31'd0, rbusy_b[i]}, {31'd0, bz});
            model_read(1'b0, i, d, bz);
            chk($sformatf("nb rdata%0d", i), rdata_n[i*32 +: 32], d);
            chk($sformatf("nb rbusy%0d", i), {31'd0, rbusy_n[i]}, {31'd0, bz});
        end
        chk("byp init_done", {31'd0, init_b}, {31'd0, m_run});
        chk("nb init_done", {31'd0, init_n}, {31'd0, m_run});
    endtask

    // Inputs are stable since the last negedge; check, then advance one clock.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        we        = 8'h0;
        waddr     = 10'h0;
        wdata     = 64'h0;
        iss_valid = 2'b0;
        iss_addr  = 10'h0;
    endtask

    // Run the sweep with garbage traffic (incl. r5 <= 0x1234) and measure its length.
    task automatic sweep_count();
        int k;
        k = 0;
        while (init_b == 1'b0 && k < 100) begin
            we        = {4'($urandom), 4'hF};
            waddr     = {5'($urandom), 5'd5};
            wdata     = {32'($urandom), 32'h0000_1234};
            iss_valid = 2'($urandom);
            iss_addr  = 10'($urandom);
            raddr     = 20'($urandom);
            step();
            k++;
        end
        chk("sweep length", 32'(k), 32'd32);
        idle();
    endtask

    typedef struct {
        logic [4:0]  ra;
        logic [3:0]  we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] eb;
        logic        ebz;
        logic [31:0] en;
        logic        enz;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{5'd7, 4'hF, 5'd7, 32'hAABBCCDD, 4'h3, 5'd7, 32'h11223344, 1'b0, 5'd0, 32'hAABB3344, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{5'd7, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hAABB3344, 1'b0, 32'hAABB3344, 1'b0};
        tbl[2]  = '{5'd9, 4'hF, 5'd9, 32'hDEADBEEF, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{5'd9, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{5'd3, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[5]  = '{5'd3, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1};
        tbl[6]  = '{5'd3, 4'h1, 5'd3, 32'h000000A5, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h000000A5, 1'b0, 32'h0, 1'b1};
        tbl[7]  = '{5'd3, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h000000A5, 1'b0, 32'h000000A5, 1'b0};
        tbl[8]  = '{5'd3, 4'h0, 5'd0, 32'h0, 4'h2, 5'd3, 32'h00005A00, 1'b1, 5'd3, 32'h00005AA5, 1'b0, 32'h000000A5, 1'b0};
        tbl[9]  = '{5'd3, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h00005AA5, 1'b1, 32'h00005AA5, 1'b1};
        tbl[10] = '{5'd0, 4'hF, 5'd0, 32'hFFFFFFFF, 4'h0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[11] = '{5'd0, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[12] = '{5'd4, 4'h0, 5'd0, 32'h0, 4'hF, 5'd4, 32'h00000055, 1'b1, 5'd4, 32'h00000055, 1'b0, 32'h0, 1'b0};
        tbl[13] = '{5'd4, 4'h0, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h00000055, 1'b1, 32'h00000055, 1'b1};

        reset = 1'b1;
        raddr = 20'h0;
        idle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        step();
        reset = 1'b0;

        // First sweep, then every register must read zero.
        sweep_count();
        for (int a = 0; a < 32; a += 4) begin
            raddr = {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)};
            #1;
            for (int i = 0; i < 4; i++)
                chk($sformatf("post-sweep r%0d", a + i), rdata_b[i*32 +: 32], 32'h0);
            step();
        end

        // Directed vectors.
        for (int v = 0; v < 14; v++) begin
            raddr     = {15'($urandom), tbl[v].ra};
            we        = {tbl[v].we1, tbl[v].we0};
            waddr     = {tbl[v].wa1, tbl[v].wa0};
            wdata     = {tbl[v].wd1, tbl[v].wd0};
            iss_valid = {1'b0, tbl[v].iv};
            iss_addr  = {5'd0, tbl[v].ia};
            #1;
            chk($sformatf("vec%0d byp rdata", v), rdata_b[31:0], tbl[v].eb);
            chk($sformatf("vec%0d byp rbusy", v), {31'd0, rbusy_b[0]}, {31'd0, tbl[v].ebz});
            chk($sformatf("vec%0d nb rdata", v), rdata_n[31:0], tbl[v].en);
            chk($sformatf("vec%0d nb rbusy", v), {31'd0, rbusy_n[0]}, {31'd0, tbl[v].enz});
            step();
        end

        // Mid-operation reset with r4 = 0x55 and busy.
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep_count();
        raddr = {15'd0, 5'd4};
        #1;
        chk("r4 after reset", rdata_b[31:0], 32'h0);
        chk("r4 busy after reset", {31'd0, rbusy_b[0]}, 32'd0);
        step();

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) raddr[i*5 +: 5] = 5'($urandom_range(0, 7));
            we        = 8'($urandom);
            waddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata     = {32'($urandom), 32'($urandom)};
            iss_valid = 2'($urandom);
            iss_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
